// File: rtl/fetch_pc_unit.sv
// Fetch stage and PC-update logic for the sequential Y86-64 core.
// Holds the PC, a byte-addressed instruction memory, the retired-instruction
// counter and the processor-status state machine (RUN / HALTED / FAULT).
module fetch_pc_unit #(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Enable,
    input  logic        Condition,
    input  logic [63:0] valM,
    input  logic        prog_we,
    input  logic [63:0] prog_addr,
    input  logic [7:0]  prog_data,
    output logic [63:0] PC,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [2:0]  Stat,
    output logic [63:0] InstrCount
);

    localparam int          AW      = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [63:0] MEM_TOP = 64'(IMEM_BYTES);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] cnt_q, cnt_d;
    logic [2:0]  flt_q, flt_d;

    logic [7:0]  mem [IMEM_BYTES];
    logic [7:0]  ib  [10];

    logic [3:0]  f_icode, f_ifun, f_ra, f_rb, f_len;
    logic [63:0] f_valc, f_valp, next_pc;
    logic [64:0] end_addr;
    logic [2:0]  chk_stat;

    // Program-load port; memory has no reset so contents survive Rst_n.
    always_ff @(posedge Clk) begin
        if (prog_we && (prog_addr < MEM_TOP))
            mem[prog_addr[AW-1:0]] <= prog_data;
    end

    // Grab the ten bytes starting at PC; bytes past the end read as zero.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            ib[i] = 8'h00;
            if ((pc_q + 64'(i)) < MEM_TOP)
                ib[i] = mem[AW'(pc_q + 64'(i))];
        end
    end

    // Split the instruction, size it, run the fault checks and pick next PC.
    always_comb begin
        f_icode = ib[0][7:4];
        f_ifun  = ib[0][3:0];
        case (f_icode)
            4'h2, 4'h6, 4'hA, 4'hB: f_len = 4'd2;
            4'h7, 4'h8:             f_len = 4'd9;
            4'h3, 4'h4, 4'h5:       f_len = 4'd10;
            default:                f_len = 4'd1;
        endcase
        if (f_len == 4'd2 || f_len == 4'd10) begin
            f_ra = ib[1][7:4];
            f_rb = ib[1][3:0];
        end else begin
            f_ra = 4'hF;
            f_rb = 4'hF;
        end
        case (f_icode)
            4'h3, 4'h4, 4'h5: f_valc = {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]};
            4'h7, 4'h8:       f_valc = {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]};
            default:          f_valc = 64'd0;
        endcase
        f_valp   = pc_q + {60'd0, f_len};
        // 65-bit sum so a wrap past 2^64 still counts as out of range
        end_addr = {1'b0, pc_q} + {61'd0, f_len};

        if (pc_q >= MEM_TOP || end_addr > {1'b0, MEM_TOP})
            chk_stat = STAT_ADR;
        else if (f_icode > 4'hB)
            chk_stat = STAT_INS;
        else if (f_icode == 4'h0)
            chk_stat = STAT_HLT;
        else
            chk_stat = STAT_AOK;

        case (f_icode)
            4'h8:    next_pc = f_valc;
            4'h7:    next_pc = (f_ifun == 4'h0 || Condition) ? f_valc : f_valp;
            4'h9:    next_pc = valM;
            default: next_pc = f_valp;
        endcase
    end

    // Next-state: only RUN with Enable advances; HALTED and FAULT hold.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        flt_d   = flt_q;
        if (state_q == RUN && Enable) begin
            case (chk_stat)
                STAT_AOK: begin
                    pc_d  = next_pc;
                    cnt_d = cnt_q + 64'd1;
                end
                STAT_HLT: begin
                    state_d = HALTED;
                    cnt_d   = cnt_q + 64'd1;
                end
                default: begin
                    state_d = FAULT;
                    flt_d   = chk_stat;
                end
            endcase
        end
    end

    // Architectural state registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= 64'd0;
            flt_q   <= STAT_AOK;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            flt_q   <= flt_d;
        end
    end

    // Outside RUN the stage presents a nop so downstream writes nothing.
    always_comb begin
        PC         = pc_q;
        InstrCount = cnt_q;
        if (state_q == RUN) begin
            icode = f_icode;
            ifun  = f_ifun;
            rA    = f_ra;
            rB    = f_rb;
            valC  = f_valc;
            valP  = f_valp;
            Stat  = chk_stat;
        end else begin
            icode = 4'h1;
            ifun  = 4'h0;
            rA    = 4'hF;
            rB    = 4'hF;
            valC  = 64'd0;
            valP  = pc_q;
            Stat  = (state_q == HALTED) ? STAT_HLT : flt_q;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: decode, branches, call/ret, faults,
// stall and asynchronous reset, with hand-computed expectations.
module tb_fetch_pc_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Enable;
    logic        Condition;
    logic [63:0] valM;
    logic        prog_we;
    logic [63:0] prog_addr;
    logic [7:0]  prog_data;
    logic [63:0] PC;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [2:0]  Stat;
    logic [63:0] InstrCount;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(.IMEM_BYTES(1024), .RESET_PC(64'd0)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .Condition(Condition),
        .valM(valM), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .PC(PC), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .Stat(Stat), .InstrCount(InstrCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: inputs are changed and outputs sampled at the negedge
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic wr(input logic [63:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge Clk);
        prog_we   = 1'b0;
    endtask

    task automatic wr_dest(input logic [63:0] a, input logic [7:0] op, input logic [63:0] dest);
        wr(a, op);
        for (int i = 0; i < 8; i++) wr(a + 64'(i + 1), dest[i*8 +: 8]);
    endtask

    initial begin
        Rst_n = 1'b0; Enable = 1'b1; Condition = 1'b0; valM = 64'd0;
        prog_we = 1'b0; prog_addr = 64'd0; prog_data = 8'd0;
        @(negedge Clk);

        // irmovq $0x1122334455667788,%rbx ; halt
        wr(0, 8'h30); wr(1, 8'hF3);
        wr(2, 8'h88); wr(3, 8'h77); wr(4, 8'h66); wr(5, 8'h55);
        wr(6, 8'h44); wr(7, 8'h33); wr(8, 8'h22); wr(9, 8'h11);
        wr(10, 8'h00);
        Rst_n = 1'b1;
        check("rst_pc",    PC, 64'd0);
        check("rst_stat",  64'(Stat), 64'd1);
        check("rst_cnt",   InstrCount, 64'd0);
        check("irm_icode", 64'(icode), 64'd3);
        check("irm_ra",    64'(rA), 64'hF);
        check("irm_rb",    64'(rB), 64'd3);
        check("irm_valc",  valC, 64'h1122334455667788);
        check("irm_valp",  valP, 64'd10);
        step();
        check("hlt_pc",    PC, 64'd10);
        check("hlt_stat",  64'(Stat), 64'd2);
        step();
        check("hltd_stat", 64'(Stat), 64'd2);
        check("hltd_cnt",  InstrCount, 64'd2);
        check("hltd_icode", 64'(icode), 64'd1);
        check("hltd_rb",   64'(rB), 64'hF);
        check("hltd_valp", valP, 64'd10);
        step();
        check("hltd_pc",   PC, 64'd10);
        check("hltd_cnt2", InstrCount, 64'd2);

        // jne 0x20, not taken
        Rst_n = 1'b0;
        wr_dest(0, 8'h74, 64'h20);
        Rst_n = 1'b1; Condition = 1'b0;
        check("jne_valc",  valC, 64'h20);
        check("jne_valp",  valP, 64'd9);
        step();
        check("jne_nt_pc", PC, 64'd9);
        // jne 0x20, taken
        Rst_n = 1'b0; @(negedge Clk); Rst_n = 1'b1; Condition = 1'b1;
        step();
        check("jne_t_pc",  PC, 64'h20);
        // jmp ignores Condition
        Rst_n = 1'b0;
        wr(0, 8'h70);
        Rst_n = 1'b1; Condition = 1'b0;
        step();
        check("jmp_pc",    PC, 64'h20);

        // call 0x40 ; ret at 0x40 returning to 9
        Rst_n = 1'b0;
        wr_dest(0, 8'h80, 64'h40);
        wr(64'h40, 8'h90);
        Rst_n = 1'b1; valM = 64'd9;
        step();
        check("call_pc",   PC, 64'h40);
        check("ret_icode", 64'(icode), 64'd9);
        step();
        check("ret_pc",    PC, 64'd9);
        check("ret_cnt",   InstrCount, 64'd2);

        // invalid instruction 0xC0
        Rst_n = 1'b0;
        wr(0, 8'hC0);
        Rst_n = 1'b1;
        check("ins_stat0", 64'(Stat), 64'd4);
        step();
        check("ins_stat",  64'(Stat), 64'd4);
        check("ins_pc",    PC, 64'd0);
        check("ins_cnt",   InstrCount, 64'd0);
        check("ins_icode", 64'(icode), 64'd1);
        step();
        check("ins_hold",  64'(Stat), 64'd4);

        // jmp to IMEM_BYTES-5 where a 10-byte irmovq overruns memory;
        // the write to address IMEM_BYTES must not alias onto address 0
        Rst_n = 1'b0;
        wr_dest(0, 8'h70, 64'd1019);
        wr(64'd1019, 8'h30);
        wr(64'd1024, 8'hC0);
        Rst_n = 1'b1;
        check("oob_wr",    64'(icode), 64'd7);
        step();
        check("adr_pc0",   PC, 64'd1019);
        check("adr_stat0", 64'(Stat), 64'd3);
        step();
        check("adr_stat",  64'(Stat), 64'd3);
        check("adr_pc",    PC, 64'd1019);
        check("adr_cnt",   InstrCount, 64'd1);

        // stall, then asynchronous reset between edges
        Rst_n = 1'b0;
        wr(0, 8'h10); wr(1, 8'h10); wr(2, 8'h10); wr(3, 8'h10);
        Rst_n = 1'b1;
        step();
        check("nop_pc",    PC, 64'd1);
        Enable = 1'b0;
        step(); step(); step();
        check("stall_pc",  PC, 64'd1);
        check("stall_cnt", InstrCount, 64'd1);
        Enable = 1'b1;
        step();
        check("resume_pc", PC, 64'd2);
        check("resume_cnt", InstrCount, 64'd2);
        #2 Rst_n = 1'b0;
        #1;
        check("arst_pc",   PC, 64'd0);
        check("arst_stat", 64'(Stat), 64'd1);
        check("arst_cnt",  InstrCount, 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        check("mem_kept",  64'(icode), 64'd1);
        check("mem_valp",  valP, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch stage plus PC-update logic of the sequential Y86-64 core; directly upstream of the decode/writeback stage.
- Holds the PC register and a byte-addressed instruction memory.
- Splits the instruction at PC into icode/ifun/rA/rB/valC/valP, computes the next PC from downstream results, and runs a processor-status state machine (AOK/HLT/ADR/INS).

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes.
- RESET_PC, 64'd0, PC value loaded on reset.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Rst_n  input  1  asynchronous active-low reset.
- Enable  input  1  1 = retire current instruction at this posedge; 0 = stall (PC, state, counter held).
- Condition  input  1  condition result from execute for the current instruction.
- valM  input  64  memory read value for the current instruction (ret target).
- prog_we  input  1  program-load byte write enable.
- prog_addr  input  64  program-load byte address.
- prog_data  input  8  program-load byte.
- PC  output  64  current program counter.
- icode, ifun, rA, rB  output  4 each  fetched instruction fields.
- valC  output  64  constant word, little-endian.
- valP  output  64  PC + instruction length.
- Stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- InstrCount  output  64  number of retired instructions.

Behaviour:
- Reset (async, Rst_n=0):
  - PC=RESET_PC, state=RUN, Stat=1, InstrCount=0.
  - Memory contents are not cleared.
- Program load: on posedge with prog_we=1 and prog_addr<IMEM_BYTES, mem[prog_addr]<=prog_data. Out-of-range writes are ignored. Writes are legal in any state and in reset; they take effect for fetch on the next cycle.
- Fetch is combinational from PC:
  - byte0 = {icode,ifun}.
  - Lengths: 0,1,9 → 1; 2,6,A,B → 2; 7,8 → 9; 3,4,5 → 10.
  - rA/rB come from byte1 for lengths 2 and 10; otherwise both are 4'hF.
  - valC = bytes 2..9 for icode 3,4,5; bytes 1..8 for icode 7,8; 0 otherwise.
  - valP = PC + length.
- Fault checks, evaluated in RUN, in priority order:
  - ADR if PC >= IMEM_BYTES, or PC + length > IMEM_BYTES (64-bit compare; overflow counts as ADR).
  - INS if icode > 4'hB.
  - HLT if icode = 0.
  - Otherwise AOK.
- Next PC:
  - icode 8 (call) → valC.
  - icode 7 (jXX): valC if ifun=0 or Condition=1; else valP.
  - icode 9 (ret) → valM.
  - Otherwise → valP.
- State machine: RUN, HALTED, FAULT.
  - RUN at posedge with Enable=1:
    - AOK: PC<=next PC, InstrCount+1.
    - HLT: →HALTED, PC held, InstrCount+1.
    - ADR or INS: →FAULT, PC held, fault code latched, InstrCount unchanged.
  - RUN with Enable=0: nothing changes.
  - HALTED: Stat=2. FAULT: Stat=latched code (3 or 4).
  - Both HALTED and FAULT are absorbing until reset.
- Stat in RUN is combinational from the fault check, so HLT/ADR/INS is visible during the offending cycle.
- In HALTED/FAULT: icode=1, ifun=0, rA=rB=F, valC=0, valP=PC. This is a nop, so downstream performs no register writes.
- Reset mid-operation forces the reset values immediately, independent of Clk.
- A ret to an out-of-range valM is accepted; the next cycle reports ADR.

Test Plan:
- Load irmovq $0x1122334455667788,%rbx (30 F3 88 77 66 55 44 33 22 11) at 0, halt at 10 → cycle0: icode=3, rA=F, rB=3, valC=0x1122334455667788, valP=10. Next: PC=10, Stat=2. Then state HALTED, InstrCount=2, outputs nop.
- jne (74) to 0x20 at 0, Condition=0 → PC becomes 9. Same with Condition=1 → PC=0x20. jmp (70) with Condition=0 → PC=0x20.
- call 0x40 at 0 then ret at 0x40, valM=9 driven → PC sequence 0 → 0x40 → 9, InstrCount=2.
- Byte 0xC0 at PC=0 → Stat=4 in the same cycle. After posedge: FAULT, PC=0, InstrCount=0, icode output=1.
- irmovq at PC=IMEM_BYTES-5 → Stat=3, FAULT. Separately, a prog_we write to addr IMEM_BYTES is ignored.
- Enable=0 for 3 cycles mid-program → PC and InstrCount frozen. Rst_n pulsed low between clock edges → PC=0 and Stat=1 immediately; memory retained.
